// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter
//   Shares one registered bitwise logic unit between NREQ requesters.
//   Each requester issues one operation at a time (valid/ready). One
//   request is granted per transaction, its result is computed and
//   registered, then held on the single response port until accepted.
//   Only one transaction is in flight at a time, so the peak rate is
//   one response every two cycles.
//
//   Op codes: 0 NOT, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR,
//             7 reserved (rsp_data = 0, rsp_err = 1).
//
//   Build option:
//     LOGIC_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                              undefined -> round-robin from a rotating ptr
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     req_valid  in   [NREQ]        per-requester request valid
//     req_ready  out  [NREQ]        one-hot (or zero) grant, IDLE only
//     req_op     in   [3*NREQ]      op code, requester i at [3i+2:3i]
//     req_a      in   [WIDTH*NREQ]  operand A, requester i at [WIDTH*i +: WIDTH]
//     req_b      in   [WIDTH*NREQ]  operand B, same packing, unused by NOT
//     rsp_valid  out  response held valid
//     rsp_ready  in   consumer accepts the response
//     rsp_id     out  [IDW]   index of the owning requester
//     rsp_data   out  [WIDTH] result
//     rsp_err    out  reserved op code was issued
module logic_op_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [3*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_a,
   input  logic [WIDTH*NREQ-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    rsp_err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESP = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;

   logic [PW-1:0]     win;
   logic              found;
   logic              grant;

   // ---------------------------------------------------------------
   // Winner selection
   // ---------------------------------------------------------------
`ifdef LOGIC_ARB_FIXED_PRIO_EN
   // Scan high to low so the lowest valid index is the last writer.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found = 1'b1;
            win   = PW'(i);
         end
      end
   end
`else
   logic [PW-1:0] ptr_q, ptr_d;
   int            rr_idx;

   // Search order is ptr, ptr+1, ... wrapping modulo NREQ. Scanning the
   // offsets high to low leaves the closest valid index to ptr as winner.
   always_comb begin
      found  = 1'b0;
      win    = '0;
      rr_idx = 0;
      for (int k = NREQ-1; k >= 0; k--) begin
         rr_idx = int'(ptr_q) + k;
         if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
         if (req_valid[rr_idx]) begin
            found = 1'b1;
            win   = PW'(rr_idx);
         end
      end
   end

   // Pointer moves past the winner only on an actual handshake.
   always_comb begin
      ptr_d = ptr_q;
      if (grant) begin
         if (win == PW'(NREQ-1)) ptr_d = '0;
         else                    ptr_d = win + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`endif

   // A grant is only offered while idle; the winner's valid is high by
   // construction, so a grant is also the handshake.
   assign grant     = (state_q == S_IDLE) && found;
   assign req_ready = grant ? (NREQ'(1) << win) : '0;

   // ---------------------------------------------------------------
   // Shared logic unit, fed from the winning lane
   // ---------------------------------------------------------------
   logic [2:0]       op_sel;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic [WIDTH-1:0] res;
   logic             res_err;

   assign op_sel = req_op[3*win +: 3];
   assign a_sel  = req_a[WIDTH*win +: WIDTH];
   assign b_sel  = req_b[WIDTH*win +: WIDTH];

   always_comb begin
      res     = '0;
      res_err = 1'b0;
      case (op_sel)
         3'd0:    res = ~a_sel;
         3'd1:    res = a_sel & b_sel;
         3'd2:    res = a_sel | b_sel;
         3'd3:    res = ~(a_sel & b_sel);
         3'd4:    res = ~(a_sel | b_sel);
         3'd5:    res = a_sel ^ b_sel;
         3'd6:    res = ~(a_sel ^ b_sel);
         default: res_err = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               state_d    = S_RESP;
               rsp_id_d   = IDW'(win);
               rsp_data_d = res;
               rsp_err_d  = res_err;
            end
         end
         S_RESP: begin
            // Response registers are not touched here, so they stay
            // stable while the consumer stalls.
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign rsp_valid = (state_q == S_RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
module tb_logic_op_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 3;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [3*NREQ-1:0]     req_op = '0;
   logic [WIDTH*NREQ-1:0] req_a = '0;
   logic [WIDTH*NREQ-1:0] req_b = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b1;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;

   logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         lane;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       e;
   } vec_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [7:0]     data;
      logic           err;
   } exp_t;

   vec_t tbl[11];
   exp_t sbq[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   int   mptr   = 0;
   logic [2:0] lop[NREQ];
   logic [7:0] la[NREQ];
   logic [7:0] lb[NREQ];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return ~a;
         3'd1: return a & b;
         3'd2: return a | b;
         3'd3: return ~(a & b);
         3'd4: return ~(a | b);
         3'd5: return a ^ b;
         3'd6: return ~(a ^ b);
         default: return 8'h00;
      endcase
   endfunction

   function automatic int exp_win(input logic [NREQ-1:0] m);
`ifdef LOGIC_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (m[i]) return i;
`else
      for (int k = 0; k < NREQ; k++) if (m[(mptr+k)%NREQ]) return (mptr+k)%NREQ;
`endif
      return 0;
   endfunction

   task automatic set_lane(input int l, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[3*l +: 3] = op;
      req_a[8*l +: 8]  = a;
      req_b[8*l +: 8]  = b;
      lop[l] = op; la[l] = a; lb[l] = b;
   endtask

   task automatic push_exp(input int w, input logic [7:0] d, input logic e);
      exp_t x;
      x.id = IDW'(w); x.data = d; x.err = e;
      sbq.push_back(x);
      mptr = (w + 1) % NREQ;
   endtask

   task automatic check_rsp(input string nm);
      exp_t x;
      if (sbq.size() == 0) begin
         chk({nm, " sb_empty"}, 32'(sbq.size()), 32'd1);
      end else begin
         x = sbq.pop_front();
         chk({nm, " id"},   32'(rsp_id),   32'(x.id));
         chk({nm, " data"}, 32'(rsp_data), 32'(x.data));
         chk({nm, " err"},  32'(rsp_err),  32'(x.err));
      end
   endtask

   // One transaction starting and ending at a falling edge with the FSM idle.
   // use_model selects expected data from the lane model instead of xd/xe.
   task automatic txn(input string nm, input logic [NREQ-1:0] mask,
                      input logic [7:0] xd, input logic xe, input bit use_model);
      int w;
      w = exp_win(mask);
      req_valid = mask;
      rsp_ready = 1'b1;
      #1;
      chk({nm, " ready"}, 32'(req_ready), 32'(1 << w));
      if (use_model) push_exp(w, ref_op(lop[w], la[w], lb[w]), (lop[w] == 3'd7));
      else           push_exp(w, xd, xe);
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      chk({nm, " valid"}, 32'(rsp_valid), 32'd1);
      check_rsp(nm);
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] hold_d;
      tbl[0]  = '{0, 3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0};
      tbl[1]  = '{2, 3'd0, 8'hA5, 8'h0F, 8'h5A, 1'b0};
      tbl[2]  = '{2, 3'd1, 8'hA5, 8'h0F, 8'h05, 1'b0};
      tbl[3]  = '{2, 3'd2, 8'hA5, 8'h0F, 8'hAF, 1'b0};
      tbl[4]  = '{2, 3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b0};
      tbl[5]  = '{2, 3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0};
      tbl[6]  = '{2, 3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b0};
      tbl[7]  = '{2, 3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0};
      tbl[8]  = '{2, 3'd7, 8'hA5, 8'h0F, 8'h00, 1'b1};
      tbl[9]  = '{1, 3'd5, 8'hFF, 8'h0F, 8'hF0, 1'b0};
      tbl[10] = '{3, 3'd3, 8'h00, 8'h00, 8'hFF, 1'b0};
      for (int l = 0; l < NREQ; l++) set_lane(l, 3'd0, 8'h00, 8'h00);

      // reset state
      #1;
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rsp_id",    32'(rsp_id),    32'd0);
      chk("rst rsp_data",  32'(rsp_data),  32'd0);
      chk("rst rsp_err",   32'(rsp_err),   32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mptr = 0;
      @(negedge clk);
      #1 chk("idle no req ready", 32'(req_ready), 32'd0);

      // table: single-requester op vectors
      for (int i = 0; i < 11; i++) begin
         set_lane(tbl[i].lane, tbl[i].op, tbl[i].a, tbl[i].b);
         txn($sformatf("vec%0d", i), NREQ'(1 << tbl[i].lane), tbl[i].d, tbl[i].e, 1'b0);
      end

      // all requesters valid: rotation and one response every 2 cycles
      for (int l = 0; l < NREQ; l++) set_lane(l, 3'(l + 1), 8'(8'h11 * (l + 1)), 8'hF0);
      for (int n = 0; n < 5; n++) begin
         int w;
         w = exp_win(4'hF);
         push_exp(w, ref_op(lop[w], la[w], lb[w]), 1'b0);
      end
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("rr valid c%0d", k), 32'(rsp_valid), 32'(k % 2));
         if (k % 2 == 1) check_rsp($sformatf("rr rsp c%0d", k));
         if (k == 9) req_valid = '0;
      end

      // consumer stall with request noise
      set_lane(1, 3'd5, 8'h3C, 8'h55);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1 chk("stall grant", 32'(req_ready), 32'(1 << exp_win(4'b0010)));
      push_exp(exp_win(4'b0010), 8'h69, 1'b0);
      hold_d = 8'h69;
      @(posedge clk); @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         req_valid = NREQ'($urandom);
         #1;
         chk($sformatf("stall valid c%0d", c), 32'(rsp_valid), 32'd1);
         chk($sformatf("stall data c%0d", c),  32'(rsp_data),  32'(hold_d));
         chk($sformatf("stall id c%0d", c),    32'(rsp_id),    32'd1);
         chk($sformatf("stall ready c%0d", c), 32'(req_ready), 32'd0);
         @(posedge clk); @(negedge clk);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      check_rsp("stall rsp");
      @(posedge clk); @(negedge clk);
      chk("stall released", 32'(rsp_valid), 32'd0);

      // wrap-around of the rotating pointer
      set_lane(2, 3'd1, 8'hFF, 8'h0F);
      set_lane(3, 3'd2, 8'h81, 8'h18);
      set_lane(0, 3'd6, 8'hC3, 8'h0F);
      txn("wrap set2", 4'b0100, 8'h00, 1'b0, 1'b1);
      txn("wrap only3", 4'b1000, 8'h00, 1'b0, 1'b1);
      txn("wrap set2b", 4'b0100, 8'h00, 1'b0, 1'b1);
      txn("wrap 0+3 a", 4'b1001, 8'h00, 1'b0, 1'b1);
      txn("wrap 0+3 b", 4'b1001, 8'h00, 1'b0, 1'b1);

      // reset while a response is pending
      set_lane(0, 3'd2, 8'h5A, 8'h01);
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      chk("mid rst pending", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid rst valid", 32'(rsp_valid), 32'd0);
      chk("mid rst data",  32'(rsp_data),  32'd0);
      chk("mid rst id",    32'(rsp_id),    32'd0);
      chk("mid rst err",   32'(rsp_err),   32'd0);
      chk("mid rst ready", 32'(req_ready), 32'd0);
      mptr = 0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      set_lane(1, 3'd4, 8'h0F, 8'h30);
      set_lane(2, 3'd0, 8'h77, 8'h00);
      txn("post rst", 4'b0110, 8'h00, 1'b0, 1'b1);

      chk("sb drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
